// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, requester ids and lock counter sizing for mem_arb
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  localparam logic SCALAR = 1'b0;
  localparam logic VECTOR = 1'b1;
  function automatic int lock_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// rr_pick2: two-way round-robin winner select with lock hold and forced yield
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_v,
  input  logic       lock_id,
  input  logic       lock_full,
  output logic       win,
  output logic       yield
);
  logic own;
  // Locked owner keeps the port until its budget is spent and the other side is waiting
  always_comb begin
    own = lock_v && req[lock_id];
    yield = own && lock_full && req[!lock_id];
    win = (own && !lock_full) ? lock_id :
          yield ? !lock_id :
          (req == 2'b01) ? SCALAR :
          (req == 2'b10) ? VECTOR : !last;
  end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin sequencer sharing one data-memory port between scalar and vector load/store
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    s_req,
  input  logic [1:0]    s_we,
  input  logic [1:0]    s_lock,
  input  logic [AW-1:0] s_addr0,
  input  logic [AW-1:0] s_addr1,
  input  logic [DW-1:0] s_wdata0,
  input  logic [DW-1:0] s_wdata1,
  output logic [1:0]    s_gnt,
  output logic [1:0]    s_rvalid,
  output logic [DW-1:0] s_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          o_stall,
  output logic          o_err
);
  localparam int LCW = lock_w(LOCK_MAX);
  state_t state, state_n;
  logic id, win, yield, last, lock_v, lock_id, lock_full, arb, gnt, done;
  logic [LCW-1:0] lock_cnt;
  rr_pick2 u_pick (
    .req(s_req),
    .last(last),
    .lock_v(lock_v),
    .lock_id(lock_id),
    .lock_full(lock_full),
    .win(win),
    .yield(yield)
  );
  // Transaction strobes, next state and combinational requester outputs
  always_comb begin
    arb = state == IDLE && |s_req;
    gnt = state == REQ && m_gnt;
    done = state == RSP && m_rvalid;
    lock_full = lock_cnt == LCW'(LOCK_MAX);
    state_n = arb ? REQ : gnt ? RSP : done ? IDLE : state;
    s_gnt = gnt ? (id ? 2'b10 : 2'b01) : 2'b00;
    o_stall = s_req[0] && !s_rvalid[0];
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Latched access, response capture, lock bookkeeping and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      id <= SCALAR;
      m_req <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      s_rvalid <= 2'b00;
      s_rdata <= '0;
      o_err <= 1'b0;
      last <= VECTOR;
      lock_v <= 1'b0;
      lock_id <= SCALAR;
      lock_cnt <= '0;
    end else begin
      m_req <= arb || (m_req && !gnt);
      s_rvalid <= done ? (id ? 2'b10 : 2'b01) : 2'b00;
      if (done) s_rdata <= m_rdata;
      if (m_rvalid && state != RSP) o_err <= 1'b1;
      if (arb) begin
        id <= win;
        m_we <= s_we[win];
        m_addr <= win ? s_addr1 : s_addr0;
        m_wdata <= win ? s_wdata1 : s_wdata0;
        if (yield) begin
          lock_v <= 1'b0;
          lock_cnt <= '0;
        end
      end
      if (gnt) begin
        last <= id;
        lock_v <= s_lock[id];
        lock_id <= s_lock[id] ? id : lock_id;
        lock_cnt <= !s_lock[id] ? '0 :
                    !(lock_v && lock_id == id) ? LCW'(1) :
                    lock_full ? lock_cnt : lock_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter and sequencer for the core's single data-memory port. It shares the port between the scalar load/store path and the vector unit's load/store stream. Each access runs as a one-outstanding request/grant/response transaction, and the arbiter generates the scalar stall. It sits between the core and memory and replaces the static `vec_exec` mux with round-robin arbitration plus bounded vector burst locking.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `LOCK_MAX`, 16, max consecutive locked grants to one requester before a forced yield (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `s_req[1:0]`  in  2  request; bit 0 = scalar, bit 1 = vector; held until `s_gnt`
- `s_we[1:0]`  in  2  write enable per requester
- `s_lock[1:0]`  in  2  requester wants to keep the port after this access
- `s_addr0`, `s_addr1`  in  AW each  addresses
- `s_wdata0`, `s_wdata1`  in  DW each  write data
- `s_gnt[1:0]`  out  2  one-cycle pulse when memory accepts that requester's access
- `s_rvalid[1:0]`  out  2  one-cycle pulse when the response is returned
- `s_rdata`  out  DW  response data, valid with `s_rvalid`
- `m_req`  out  1  memory request
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_gnt`  in  1  memory accepts the request (m_req && m_gnt = handshake)
- `m_rvalid`  in  1  response pulse; reads and writes both get exactly one
- `m_rdata`  in  DW  read data
- `o_stall`  out  1  scalar stall = `s_req[0]` && !`s_rvalid[0]`
- `o_err`  out  1  sticky; set by `m_rvalid` outside RSP

## Operation
- FSM states: IDLE, REQ, RSP.
- **IDLE**
  - If any `s_req` is set, pick a winner and latch its id, we, addr and wdata.
  - Go to REQ.
- **REQ**
  - Drive `m_req`=1 with the latched fields; they stay stable until `m_gnt`.
  - On `m_gnt`, pulse `s_gnt[id]` and go to RSP.
- **RSP**
  - On `m_rvalid`, register `m_rdata` into `s_rdata` and pulse `s_rvalid[id]` next cycle.
  - Go to IDLE in the same cycle as `m_rvalid`.
  - `s_rdata` holds its value until the next response.
- **Winner pick**
  - Lock case: if `lock_owner` is valid, that owner is requesting, and `lock_cnt` < `LOCK_MAX`, the owner wins.
  - Otherwise, if only one requester is active, it wins.
  - Otherwise, the requester that is not `last` wins.
  - `last` resets to 1 (vector), so scalar wins the first tie.
- **Lock bookkeeping**
  - On `s_gnt` with `s_lock[id]`=1: set `lock_owner`=id and increment `lock_cnt`.
  - On `s_gnt` with `s_lock[id]`=0: clear the lock and set `lock_cnt`=0.
  - Forced yield: when `lock_cnt`==`LOCK_MAX` and the other requester is active, the other wins and the lock clears.
  - If the other requester is not active at that point, the owner continues and `lock_cnt` saturates.
- `last` updates to the winner on every `s_gnt`.
- **Reset** (in any state, including mid-transaction)
  - State goes to IDLE; `lock_cnt`=0; lock is cleared; `last`=1; `o_err`=0.
  - All `s_gnt`, `s_rvalid` and `m_req` are 0; `m_we`=0.
  - `m_addr`, `m_wdata` and `s_rdata` are 0.
  - A stale `m_rvalid` arriving after reset sets `o_err` and is otherwise ignored.
- Requesters deasserting `s_req` before `s_gnt` is a protocol violation. The latched copy is still issued and its response is still delivered.

## Timing
- Arbitration decision happens in the cycle `s_req` is seen in IDLE (cycle N).
- `m_req` rises at N+1.
- Zero-wait memory (`m_gnt` at N+1, `m_rvalid` at N+2):
  - `s_gnt` at N+1
  - `s_rvalid` and `s_rdata` at N+3
  - next arbitration at N+3
- Throughput: one access per 3 cycles minimum.
- `m_req`, `m_addr`, `m_we` and `m_wdata` are registered outputs.
- `s_gnt` is combinational from `m_gnt` in REQ.
- `o_stall` is combinational and asserts in the same cycle as `s_req[0]`.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/REQ/RSP)
  - requester id constants SCALAR=0, VECTOR=1
  - lock counter width = clog2(`LOCK_MAX`+1)
- Sub-module `rr_pick2`: combinational 2-way round-robin picker with lock and forced-yield inputs, returning the winner id. The FSM, latches and counters stay in `mem_arb`.

## Test plan
- Scalar read alone: `s_req`=01, addr 0x100, zero-wait memory returning 0xDEADBEEF -> `m_req` at N+1, `s_gnt`=01 at N+1, `s_rvalid`=01 at N+3 with `s_rdata`=0xDEADBEEF, `o_stall` high at N..N+2.
- Simultaneous requests after reset, no lock -> order scalar, vector, scalar, vector; `last` alternates.
- Vector locked burst with `LOCK_MAX`=4 and scalar waiting -> 4 vector grants, then a scalar grant, then vector resumes.
- `m_gnt` delayed 3 cycles and `m_rvalid` delayed 5 cycles -> `m_addr`/`m_wdata`/`m_we` stable throughout REQ, exactly one `s_gnt` and one `s_rvalid`.
- `rst` asserted in RSP, then `m_rvalid` arrives -> no `s_rvalid`, `o_err`=1, next request served normally from IDLE.
